// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial stream, control and status bundle for seq_detect_param.
// The master drives the stream and the controls; the slave (the detector) drives the
// match pulse and the counter status.
interface seq_detect_param_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_seq;
    logic             overlap;
    logic             load;
    logic [PAT_W-1:0] load_pat;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output in_valid, in_seq, overlap, load, load_pat, cnt_clr,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
        input  in_valid, in_seq, overlap, load, load_pat, cnt_clr,
        output out, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: Moore-style serial detector for a PAT_W-bit pattern (MSB first),
// with run-time overlap/non-overlap selection and a saturating match counter.
// Defining SEQDET_LOAD_EN adds a run-time loadable pattern register; without it the
// pattern is the constant PATTERN and load/load_pat are ignored.
// The interface instance must use the same PAT_W and CNT_W as this module.
module seq_detect_param #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int               CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  hist;       // most recent accepted bits, newest in bit 0
    logic [FILL_W-1:0] fill;       // how many bits of hist belong to the current attempt
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-1:0]  next_hist;
    logic              do_load;
    logic              accept;
    logic              hit;
    logic              out_q;
    logic [CNT_W-1:0]  cnt_q;

`ifdef SEQDET_LOAD_EN
    assign do_load = bus.load;

    // Pattern register: PATTERN after reset, replaced by load_pat on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= PATTERN;
        end else if (bus.load) begin
            pat <= bus.load_pat;
        end
    end
`else
    assign do_load = 1'b0;
    assign pat     = PATTERN;

    logic unused_load;
    assign unused_load = ^{bus.load, bus.load_pat};
`endif

    // A load cycle swallows any bit offered alongside it.
    assign accept    = bus.in_valid & ~do_load;
    assign next_hist = {hist[PAT_W-2:0], bus.in_seq};
    // The completing bit is compared before it lands in hist, so PAT_W-1 bits of history suffice.
    assign hit       = accept && (fill >= FILL_ARM) && (next_hist == pat);

    // History, fill level and the registered match pulse.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples
        // the pre-edge values of the others; blocking here would chain updates within one edge.
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            out_q <= 1'b0;
        end else if (do_load) begin
            fill  <= '0;
            out_q <= 1'b0;
        end else begin
            out_q <= hit;
            if (accept) begin
                hist <= next_hist;
                if (hit && !bus.overlap) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Saturating match counter; clear beats a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = (cnt_q == CNT_MAX);
endmodule
